ppu_vram_arbiter: RTL and testbench

// Owns the PPU video-memory bus and shares it between three requesters: background fetcher,

---
 rtl/ppu_vram_pkg.sv | 31 +++
 rtl/ppu_vram_arbiter_priority_select.sv | 42 ++++
 rtl/ppu_vram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vram_pkg.sv
// Shared types and defaults for the PPU video-memory arbiter.
package ppu_vram_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_BG  = 2'd0,
    OWN_SPR = 2'd1,
    OWN_CPU = 2'd2
  } owner_e;

  // One-hot pulse vector for an owner: bit0 bg, bit1 sprite, bit2 cpu.
  function automatic logic [2:0] owner_onehot(input owner_e owner);
    logic [2:0] vec;
    case (owner)
      OWN_BG:  vec = 3'b001;
      OWN_SPR: vec = 3'b010;
      OWN_CPU: vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/ppu_vram_arbiter_priority_select.sv
// Fixed-priority requester picker: bg > sprite while rendering, CPU only otherwise.
module ppu_vram_priority_select
  import ppu_vram_pkg::*;
(
  input  logic       i_rendering,
  input  logic       i_bg_req,
  input  logic       i_spr_req,
  input  logic       i_cpu_req,
  output logic       o_any,
  output logic [2:0] o_onehot,
  output owner_e     o_owner
);

  // Pick at most one winner; fetchers and CPU never compete in the same window.
  always_comb begin
    o_any    = 1'b0;
    o_onehot = 3'b000;
    o_owner  = OWN_BG;
    if (i_rendering) begin
      if (i_bg_req) begin
        o_any    = 1'b1;
        o_onehot = 3'b001;
        o_owner  = OWN_BG;
      end else if (i_spr_req) begin
        o_any    = 1'b1;
        o_onehot = 3'b010;
        o_owner  = OWN_SPR;
      end else begin
        o_any    = 1'b0;
      end
    end else begin
      if (i_cpu_req) begin
        o_any    = 1'b1;
        o_onehot = 3'b100;
        o_owner  = OWN_CPU;
      end else begin
        o_any    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// PPU video-memory bus owner: two-phase (address, data) accesses shared between
// background fetcher, sprite fetcher and the CPU data port.
module ppu_vram_arbiter
  import ppu_vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic              i_rendering,
  input  logic              i_bg_req,
  input  logic [ADDR_W-1:0] i_bg_addr,
  output logic              o_bg_gnt,
  output logic              o_bg_valid,
  input  logic              i_spr_req,
  input  logic [ADDR_W-1:0] i_spr_addr,
  output logic              o_spr_gnt,
  output logic              o_spr_valid,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_video_address,
  output logic              o_video_rd_n,
  output logic              o_video_wr_n,
  output logic [DATA_W-1:0] o_video_data,
  input  logic [DATA_W-1:0] i_vram_data
);

  state_e            state_r,   state_nx_s;
  owner_e            owner_r,   owner_nx_s;
  logic              we_r,      we_nx_s;
  logic [ADDR_W-1:0] addr_r,    addr_nx_s;
  logic [DATA_W-1:0] wdata_r,   wdata_nx_s;
  logic [DATA_W-1:0] rd_data_r, rd_data_nx_s;
  logic              rd_n_r,    rd_n_nx_s;
  logic              wr_n_r,    wr_n_nx_s;
  logic [2:0]        gnt_r,     gnt_nx_s;
  logic [2:0]        done_r,    done_nx_s;
  logic              sel_point_s;
  logic              win_any_s;
  logic [2:0]        win_onehot_s;
  owner_e            win_owner_s;

  ppu_vram_priority_select u_select (
    .i_rendering (i_rendering),
    .i_bg_req    (i_bg_req),
    .i_spr_req   (i_spr_req),
    .i_cpu_req   (i_cpu_req),
    .o_any       (win_any_s),
    .o_onehot    (win_onehot_s),
    .o_owner     (win_owner_s)
  );

  // Next-state: finish the current phase, then start a new access at a selection point.
  always_comb begin
    state_nx_s   = state_r;
    owner_nx_s   = owner_r;
    we_nx_s      = we_r;
    addr_nx_s    = addr_r;
    wdata_nx_s   = wdata_r;
    rd_data_nx_s = rd_data_r;
    rd_n_nx_s    = rd_n_r;
    wr_n_nx_s    = wr_n_r;
    gnt_nx_s     = 3'b000;
    done_nx_s    = 3'b000;
    sel_point_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_point_s = 1'b1;
      end
      ST_ADDR: begin
        state_nx_s = ST_DATA;
        rd_n_nx_s  = 1'b1;
        wr_n_nx_s  = 1'b1;
      end
      ST_DATA: begin
        sel_point_s = 1'b1;
        state_nx_s  = ST_IDLE;
        done_nx_s   = owner_onehot(owner_r);
        if (we_r) begin
          rd_data_nx_s = rd_data_r;
        end else begin
          rd_data_nx_s = i_vram_data;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        rd_n_nx_s  = 1'b1;
        wr_n_nx_s  = 1'b1;
      end
    endcase

    if (sel_point_s && win_any_s) begin
      state_nx_s = ST_ADDR;
      owner_nx_s = win_owner_s;
      gnt_nx_s   = win_onehot_s;
      case (win_owner_s)
        OWN_BG: begin
          addr_nx_s = i_bg_addr;
          we_nx_s   = 1'b0;
        end
        OWN_SPR: begin
          addr_nx_s = i_spr_addr;
          we_nx_s   = 1'b0;
        end
        OWN_CPU: begin
          addr_nx_s = i_cpu_addr;
          we_nx_s   = i_cpu_we;
          if (i_cpu_we) begin
            wdata_nx_s = i_cpu_wdata;
          end else begin
            wdata_nx_s = wdata_r;
          end
        end
        default: begin
          addr_nx_s = addr_r;
          we_nx_s   = 1'b0;
        end
      endcase
      // Exactly one strobe goes low for the address phase.
      rd_n_nx_s = we_nx_s;
      wr_n_nx_s = ~we_nx_s;
    end else begin
      gnt_nx_s = 3'b000;
    end
  end

  // State and output registers; everything freezes while i_ce is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_BG;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
      rd_n_r    <= 1'b1;
      wr_n_r    <= 1'b1;
      gnt_r     <= 3'b000;
      done_r    <= 3'b000;
    end else if (i_ce) begin
      state_r   <= state_nx_s;
      owner_r   <= owner_nx_s;
      we_r      <= we_nx_s;
      addr_r    <= addr_nx_s;
      wdata_r   <= wdata_nx_s;
      rd_data_r <= rd_data_nx_s;
      rd_n_r    <= rd_n_nx_s;
      wr_n_r    <= wr_n_nx_s;
      gnt_r     <= gnt_nx_s;
      done_r    <= done_nx_s;
    end
  end

  assign o_bg_gnt        = gnt_r[0];
  assign o_spr_gnt       = gnt_r[1];
  assign o_cpu_gnt       = gnt_r[2];
  assign o_bg_valid      = done_r[0];
  assign o_spr_valid     = done_r[1];
  assign o_cpu_done      = done_r[2];
  assign o_rd_data       = rd_data_r;
  assign o_video_address = addr_r;
  assign o_video_rd_n    = rd_n_r;
  assign o_video_wr_n    = wr_n_r;
  assign o_video_data    = wdata_r;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Scoreboard bench for ppu_vram_arbiter: directed scenarios then randomized traffic.
module tb_ppu_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ce, rendering;
  logic          bg_req, spr_req, cpu_req, cpu_we;
  logic [AW-1:0] bg_addr, spr_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata, vram_rd;
  logic          bg_gnt, bg_valid, spr_gnt, spr_valid, cpu_gnt, cpu_done;
  logic [DW-1:0] rd_data, video_data;
  logic [AW-1:0] video_addr;
  logic          rd_n, wr_n;

  ppu_vram_arbiter dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_rendering(rendering),
    .i_bg_req(bg_req), .i_bg_addr(bg_addr), .o_bg_gnt(bg_gnt), .o_bg_valid(bg_valid),
    .i_spr_req(spr_req), .i_spr_addr(spr_addr), .o_spr_gnt(spr_gnt), .o_spr_valid(spr_valid),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_done(cpu_done), .o_rd_data(rd_data),
    .o_video_address(video_addr), .o_video_rd_n(rd_n), .o_video_wr_n(wr_n),
    .o_video_data(video_data), .i_vram_data(vram_rd)
  );

  // External VRAM seen by the DUT, and the bench's own reference memory.
  logic [DW-1:0] vram [0:(1<<AW)-1];
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  assign vram_rd = vram[video_addr];

  typedef struct { int who; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } gnt_t;
  typedef struct { int who; logic [DW-1:0] data; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the bus is a slot that is free, busy (address) or finishing (data).
  int            slot = 0;
  int            cur_who = 0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] model_rd = '0;
  bit            fresh = 1'b0;
  bit            was_reset = 1'b0;
  int            w;

  always @(posedge clk) begin
    if (wr_n === 1'b0) vram[video_addr] = video_data;
    was_reset = rst;
    fresh = ce && !rst;
    if (rst) begin
      slot = 0;
      model_rd = '0;
      gq.delete();
      rq.delete();
    end else if (ce) begin
      if (slot == 2) begin
        if (!cur_we) model_rd = mmem[cur_addr];
        rq.push_back('{cur_who, model_rd});
      end
      if (slot == 1) begin
        slot = 2;
      end else begin
        w = -1;
        if (rendering) begin
          if (bg_req) w = 0;
          else if (spr_req) w = 1;
        end else if (cpu_req) begin
          w = 2;
        end
        if (w < 0) begin
          slot = 0;
        end else begin
          slot = 1;
          cur_who = w;
          cur_we = (w == 2) ? cpu_we : 1'b0;
          cur_addr = (w == 0) ? bg_addr : (w == 1) ? spr_addr : cpu_addr;
          gq.push_back('{w, cur_addr, cur_we, cpu_wdata});
          if (cur_we) mmem[cur_addr] = cpu_wdata;
        end
      end
    end
  end

  // Monitor: compare fresh outputs against the queues, check holds while ce is low.
  logic [37:0] outs_s, snap;
  bit          have_snap = 1'b0;
  logic [2:0]  gv, rv;
  gnt_t        g;
  rsp_t        r;
  assign outs_s = {bg_gnt, spr_gnt, cpu_gnt, bg_valid, spr_valid, cpu_done,
                   rd_data, video_addr, rd_n, wr_n, video_data};

  always @(negedge clk) begin
    if (was_reset) begin
      check("reset_state", {26'd0, outs_s}, {26'd0, 6'b0, 8'h00, 14'h0000, 1'b1, 1'b1, 8'h00});
    end else if (!fresh) begin
      if (have_snap) check("ce_hold", {26'd0, outs_s}, {26'd0, snap});
    end else begin
      gv = {cpu_gnt, spr_gnt, bg_gnt};
      if (gv != 3'b000) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", {61'd0, gv}, 64'd0);
        end else begin
          g = gq.pop_front();
          check("gnt_who", {61'd0, gv}, 64'd1 << g.who);
          check("gnt_addr", {50'd0, video_addr}, {50'd0, g.addr});
          check("gnt_strobes", {62'd0, rd_n, wr_n}, g.we ? 64'd2 : 64'd1);
          if (g.we) check("gnt_wdata", {56'd0, video_data}, {56'd0, g.wdata});
        end
        if (bg_gnt) bg_req = 1'b0;
        if (spr_gnt) spr_req = 1'b0;
        if (cpu_gnt) cpu_req = 1'b0;
      end else begin
        check("idle_strobes", {62'd0, rd_n, wr_n}, 64'd3);
      end
      if (gq.size() != 0) begin
        check("gnt_missing", 64'(gq.size()), 64'd0);
        gq.delete();
      end
      rv = {cpu_done, spr_valid, bg_valid};
      if (rv != 3'b000) begin
        if (rq.size() == 0) begin
          check("rsp_unexpected", {61'd0, rv}, 64'd0);
        end else begin
          r = rq.pop_front();
          check("rsp_who", {61'd0, rv}, 64'd1 << r.who);
          check("rsp_data", {56'd0, rd_data}, {56'd0, r.data});
        end
      end
      if (rq.size() != 0) begin
        check("rsp_missing", 64'(rq.size()), 64'd0);
        rq.delete();
      end
    end
    snap = outs_s;
    have_snap = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the monitor has seen the grant for requester 'which'.
  task automatic wait_gnt(input string name, input int which);
    int n;
    logic pend;
    n = 0;
    pend = (which == 0) ? bg_req : (which == 1) ? spr_req : cpu_req;
    while (pend && n < 50) begin
      tick();
      n++;
      pend = (which == 0) ? bg_req : (which == 1) ? spr_req : cpu_req;
    end
    check(name, {63'd0, pend}, 64'd0);
  endtask

  logic [DW-1:0] v;

  initial begin
    rst = 1'b1; ce = 1'b1; rendering = 1'b0;
    bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    bg_addr = '0; spr_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      vram[i] = v;
      mmem[i] = v;
    end
    tick(); tick();
    rst = 1'b0;

    // Background read with known data.
    vram[14'h2041] = 8'h5A; mmem[14'h2041] = 8'h5A;
    rendering = 1'b1; bg_addr = 14'h2041; bg_req = 1'b1;
    wait_gnt("t2_bg_gnt", 0);
    repeat (3) tick();
    check("t2_rd_data", {56'd0, rd_data}, 64'h5A);

    // Simultaneous bg and sprite: bg first, sprite back-to-back.
    bg_addr = 14'h23C0; spr_addr = 14'h1010; bg_req = 1'b1; spr_req = 1'b1;
    wait_gnt("t3_spr_gnt", 1);
    check("t3_bg_first", {63'd0, bg_req}, 64'd0);
    repeat (3) tick();

    // CPU write held off while rendering, served once rendering drops.
    cpu_we = 1'b1; cpu_addr = 14'h3F00; cpu_wdata = 8'h0F; cpu_req = 1'b1;
    repeat (6) tick();
    check("t4_cpu_pending", {63'd0, cpu_req}, 64'd1);
    check("t4_no_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
    rendering = 1'b0;
    wait_gnt("t4_cpu_gnt", 2);
    repeat (3) tick();
    cpu_we = 1'b0; cpu_req = 1'b1;
    wait_gnt("t4_cpu_rd_gnt", 2);
    repeat (3) tick();
    check("t4_readback", {56'd0, rd_data}, 64'h0F);

    // Clock-enable stall during the address phase.
    rendering = 1'b1; bg_addr = 14'h0777; bg_req = 1'b1;
    wait_gnt("t5_bg_gnt", 0);
    ce = 1'b0;
    repeat (3) tick();
    ce = 1'b1;
    repeat (3) tick();

    // Reset during the data phase of a CPU read.
    rendering = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0123; cpu_req = 1'b1;
    wait_gnt("t6_cpu_gnt", 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_strobes", {62'd0, rd_n, wr_n}, 64'd3);
    check("t6_no_done", {63'd0, cpu_done}, 64'd0);
    cpu_addr = 14'h0456; cpu_req = 1'b1;
    wait_gnt("t6_next_gnt", 2);
    repeat (3) tick();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      ce = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) rendering = ~rendering;
      rst = ($urandom_range(0, 599) == 0);
      if (!bg_req && $urandom_range(0, 2) == 0) begin
        bg_addr = AW'($urandom); bg_req = 1'b1;
      end else if (bg_req && $urandom_range(0, 39) == 0) begin
        bg_req = 1'b0;
      end
      if (!spr_req && $urandom_range(0, 2) == 0) begin
        spr_addr = AW'($urandom); spr_req = 1'b1;
      end else if (spr_req && $urandom_range(0, 39) == 0) begin
        spr_req = 1'b0;
      end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_addr = AW'($urandom); cpu_we = 1'($urandom);
        cpu_wdata = DW'($urandom); cpu_req = 1'b1;
      end else if (cpu_req && $urandom_range(0, 39) == 0) begin
        cpu_req = 1'b0;
      end
      tick();
    end

    rst = 1'b0; ce = 1'b1;
    bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0;
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
